// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Build option: IF_PREFETCH_EN selects a two-entry fetch buffer that keeps
// fetching under stall; without it the buffer holds a single entry.
package if_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  typedef logic [WORD_ADDR_W-1:0] WordAddrBus;
  typedef logic [WORD_DATA_W-1:0] WordDataBus;

  localparam WordDataBus ISA_NOP = 32'h0;

  typedef enum logic {
    IF_ST_FETCH   = 1'b0,
    IF_ST_DISCARD = 1'b1
  } if_state_e;

`ifdef IF_PREFETCH_EN
  localparam int IF_BUF_DEPTH = 2;
`else
  localparam int IF_BUF_DEPTH = 1;
`endif
  localparam int IF_CNT_W = $clog2(IF_BUF_DEPTH + 1);

  typedef struct packed {
    WordAddrBus pc;
    WordDataBus insn;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Small synchronous FIFO of fetched {pc, insn} pairs. Clear wins over push.
// The caller never pushes when full nor pops when empty.
module if_fetch_buf import if_stage_pkg::*; #(
  parameter int DEPTH = IF_BUF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // entry storage, no reset needed: count gates visibility
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, imem request/ready handshake,
// fetch buffering and the IF/ID output register.
// Build option: IF_PREFETCH_EN (deeper buffer, fetching continues under stall).
module if_stage import if_stage_pkg::*; #(
  parameter WordAddrBus RESET_VECTOR = 30'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  WordAddrBus new_pc,
  input  logic       br_taken,
  input  WordAddrBus br_addr,
  output logic       imem_req,
  output WordAddrBus imem_addr,
  input  logic       imem_rdy,
  input  WordDataBus imem_rd_data,
  output WordAddrBus if_pc,
  output WordDataBus if_insn,
  output logic       if_en,
  output logic       busy
);

  if_state_e            state, state_n;
  WordAddrBus           fetch_pc, fetch_pc_n, req_addr, target;
  logic                 req_q, req_n, hold, can_launch;
  logic                 redirect, accept, bypass, push, pop, buf_empty;
  logic [IF_CNT_W-1:0]  count, cnt_n;
  fetch_entry_t         head;

  // flush beats a branch; a branch is only honoured when not stalled
  assign redirect  = flush | (br_taken & ~stall);
  assign target    = flush ? new_pc : br_addr;
  // an issued request must stay on the bus until memory answers
  assign hold      = req_q & ~imem_rdy;
  assign accept    = req_q & imem_rdy & (state == IF_ST_FETCH) & ~redirect;
  assign buf_empty = (count == '0);
  assign pop       = ~redirect & ~stall & ~buf_empty;
  assign bypass    = accept & buf_empty & ~stall;
  assign push      = accept & ~bypass;
  assign cnt_n     = redirect ? '0 : count + IF_CNT_W'(push) - IF_CNT_W'(pop);

`ifdef IF_PREFETCH_EN
  assign can_launch = (cnt_n < IF_CNT_W'(IF_BUF_DEPTH));
`else
  assign can_launch = (cnt_n < IF_CNT_W'(IF_BUF_DEPTH)) & ~stall;
`endif

  assign imem_req  = req_q;
  assign imem_addr = req_addr;
  assign busy      = imem_req & ~imem_rdy;

  if_fetch_buf #(.DEPTH(IF_BUF_DEPTH), .CNT_W(IF_CNT_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clr     (redirect),
    .wr_data ('{pc: req_addr, insn: imem_rd_data}),
    .rd_data (head),
    .count   (count)
  );

  // next PC, FSM transition and request launch
  always_comb begin
    state_n    = hold ? (redirect ? IF_ST_DISCARD : state) : IF_ST_FETCH;
    fetch_pc_n = fetch_pc;
    if (redirect)    fetch_pc_n = target;
    else if (accept) fetch_pc_n = fetch_pc + WORD_ADDR_W'(1);
    req_n      = hold | can_launch;
  end

  // FSM, PC and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IF_ST_FETCH;
      fetch_pc <= RESET_VECTOR;
      req_q    <= 1'b0;
      req_addr <= RESET_VECTOR;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_q    <= req_n;
      if (!hold) req_addr <= fetch_pc_n;
    end
  end

  // IF/ID register: bubble on redirect, freeze on stall, else oldest word
  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc   <= RESET_VECTOR;
      if_insn <= ISA_NOP;
      if_en   <= 1'b0;
    end else if (redirect) begin
      if_insn <= ISA_NOP;
      if_en   <= 1'b0;
    end else if (!stall) begin
      if (!buf_empty) begin
        if_pc   <= head.pc;
        if_insn <= head.insn;
        if_en   <= 1'b1;
      end else if (bypass) begin
        if_pc   <= req_addr;
        if_insn <= imem_rd_data;
        if_en   <= 1'b1;
      end else begin
        if_insn <= ISA_NOP;
        if_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns word = {2'b0, address}
// after a programmable number of wait cycles.
module tb_if_stage;
  import if_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset, stall, flush, br_taken;
  WordAddrBus new_pc, br_addr;
  logic       imem_req, imem_rdy, if_en, busy;
  WordAddrBus imem_addr, if_pc;
  WordDataBus imem_rd_data, if_insn;

  int waits = 0;
  int wcnt  = 0;
  int n_chk = 0;
  int n_fail = 0;

  if_stage #(.RESET_VECTOR(30'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rd_data(imem_rd_data),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en), .busy(busy)
  );

  always #5 clk = ~clk;

  assign imem_rdy     = imem_req && (wcnt >= waits);
  assign imem_rd_data = {2'b00, imem_addr};

  always @(posedge clk) begin
    if (reset || !imem_req || imem_rdy) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int k;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0;
    repeat (2) tick();
    chk("rst_pc",   32'(if_pc), 32'h0);
    chk("rst_insn", if_insn, 32'h0);
    chk("rst_en",   32'(if_en), 32'h0);
    chk("rst_req",  32'(imem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    reset = 1'b0;

    // zero-wait streaming
    tick();
    chk("zw_req1",  32'(imem_req), 32'h1);
    chk("zw_addr0", 32'(imem_addr), 32'h0);
    chk("zw_en0",   32'(if_en), 32'h0);
    tick();
    chk("zw_en1",   32'(if_en), 32'h1);
    chk("zw_pc0",   32'(if_pc), 32'h0);
    chk("zw_addr1", 32'(imem_addr), 32'h1);
    tick();
    chk("zw_pc1",   32'(if_pc), 32'h1);
    chk("zw_insn1", if_insn, 32'h1);
    tick();
    chk("zw_pc2",   32'(if_pc), 32'h2);
    chk("zw_addr3", 32'(imem_addr), 32'h3);

    // two wait cycles per fetch
    waits = 2;
    tick();
    chk("w2_en_a",   32'(if_en), 32'h0);
    chk("w2_busy_a", 32'(busy), 32'h1);
    chk("w2_addr_a", 32'(imem_addr), 32'h3);
    tick();
    chk("w2_en_b",   32'(if_en), 32'h0);
    chk("w2_busy_b", 32'(busy), 32'h0);
    chk("w2_addr_b", 32'(imem_addr), 32'h3);
    tick();
    chk("w2_en_c",   32'(if_en), 32'h1);
    chk("w2_pc3",    32'(if_pc), 32'h3);
    chk("w2_busy_c", 32'(busy), 32'h1);
    chk("w2_addr4",  32'(imem_addr), 32'h4);
    tick(); tick();
    chk("w2_en_e",   32'(if_en), 32'h0);
    tick();
    chk("w2_en_f",   32'(if_en), 32'h1);
    chk("w2_pc4",    32'(if_pc), 32'h4);

    // branch while a 3-wait fetch is pending
    waits = 3;
    tick();
    chk("br_busy", 32'(busy), 32'h1);
    chk("br_addr5", 32'(imem_addr), 32'h5);
    br_taken = 1'b1; br_addr = 30'h100;
    tick();
    br_taken = 1'b0;
    chk("br_bubble", 32'(if_en), 32'h0);
    chk("br_hold_addr", 32'(imem_addr), 32'h5);
    chk("br_hold_req", 32'(imem_req), 32'h1);
    tick();
    waits = 0;
    chk("br_drop_en", 32'(if_en), 32'h0);
    tick();
    chk("br_no_stale", 32'(if_en), 32'h0);
    chk("br_new_addr", 32'(imem_addr), 32'h100);
    tick();
    chk("br_en", 32'(if_en), 32'h1);
    chk("br_pc", 32'(if_pc), 32'h100);
    chk("br_insn", if_insn, 32'h100);

    // stall for 4 cycles mid-stream
    stall = 1'b1;
    tick();
    chk("st_pc_a", 32'(if_pc), 32'h100);
`ifdef IF_PREFETCH_EN
    chk("st_prefetch_req", 32'(imem_req), 32'h1);
    chk("st_prefetch_addr", 32'(imem_addr), 32'h102);
`else
    chk("st_noreq", 32'(imem_req), 32'h0);
`endif
    tick(); tick(); tick();
    chk("st_pc_d", 32'(if_pc), 32'h100);
    chk("st_en_d", 32'(if_en), 32'h1);
    chk("st_insn_d", if_insn, 32'h100);
    stall = 1'b0;
    tick();
    chk("st_rel_pc101", 32'(if_pc), 32'h101);
    tick();
    chk("st_rel_pc102", 32'(if_pc), 32'h102);
    tick();
    chk("st_rel_pc103", 32'(if_pc), 32'h103);
    chk("st_rel_en", 32'(if_en), 32'h1);

    // flush and branch together under stall: flush wins
    stall = 1'b1; flush = 1'b1; new_pc = 30'h40; br_taken = 1'b1; br_addr = 30'h80;
    tick();
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    chk("fl_bubble", 32'(if_en), 32'h0);
    chk("fl_addr", 32'(imem_addr), 32'h40);
    k = 0;
    while (!if_en && k < 6) begin
      tick();
      k++;
    end
    chk("fl_found", 32'(if_en), 32'h1);
    chk("fl_pc", 32'(if_pc), 32'h40);

    // PC wrap at the top of the address space
    flush = 1'b1; new_pc = 30'h3FFF_FFFF;
    tick();
    flush = 1'b0;
    chk("wr_bubble", 32'(if_en), 32'h0);
    chk("wr_addr_top", 32'(imem_addr), 32'h3FFF_FFFF);
    tick();
    chk("wr_pc_top", 32'(if_pc), 32'h3FFF_FFFF);
    chk("wr_addr_0", 32'(imem_addr), 32'h0);
    tick();
    chk("wr_pc_0", 32'(if_pc), 32'h0);
    chk("wr_en_0", 32'(if_en), 32'h1);

    // reset while a request is waiting
    waits = 3;
    tick();
    chk("mr_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("mr_req", 32'(imem_req), 32'h0);
    chk("mr_busy0", 32'(busy), 32'h0);
    chk("mr_en", 32'(if_en), 32'h0);
    chk("mr_pc", 32'(if_pc), 32'h0);
    reset = 1'b0; waits = 0;
    tick();
    chk("mr_req1", 32'(imem_req), 32'h1);
    chk("mr_addr0", 32'(imem_addr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage: generates the word-addressed PC, fetches instructions from instruction memory over a request/ready handshake, and presents `if_pc`/`if_insn`/`if_en` as the IF/ID pipeline register feeding the decoder. It absorbs memory wait states with bubbles and holds output under stall. Branch redirects from the decoder and flush/redirects from pipeline control discard stale fetches.

## Interface
- `RESET_VECTOR`, 30'h0, word address of the first fetch after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold IF/ID register; from pipeline control (`ld_hazard`, bus busy).
- `flush`  in  1  redirect to `new_pc`, e.g. exception vector or EXRT return; effective even under stall.
- `new_pc`  in  30  flush target.
- `br_taken`  in  1  decoder branch redirect.
- `br_addr`  in  30  branch target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  30  fetch word address.
- `imem_rdy`  in  1  response valid this cycle.
- `imem_rd_data`  in  32  instruction word, valid with `imem_rdy`.
- `if_pc`  out  30  PC of `if_insn`.
- `if_insn`  out  32  instruction to the decoder.
- `if_en`  out  1  `if_insn` valid.
- `busy`  out  1  `imem_req && !imem_rdy`.

## Operation
- Internal state: `fetch_pc` (30b), FSM {`FETCH`, `DISCARD`}, fetch buffer of depth D (entries {pc, insn}), outstanding flag.
- Priority each cycle: `reset` > `flush` > (`br_taken && !stall`) > `stall` > normal. `br_taken` is ignored while `stall`=1.
- Request rule: once `imem_req` rises, `imem_req` and `imem_addr` stay constant until the cycle `imem_rdy`=1. `imem_addr`=`fetch_pc`. A new request launches in `FETCH` only when (buffer count + outstanding) < D, or when the current response is being consumed the same cycle.
- On accepted response in `FETCH`: `fetch_pc` <= `fetch_pc`+1 (mod 2^30, wraps 3FFF_FFFF→0). The word is pushed, or bypassed straight to output if the buffer is empty and `stall`=0.
- Output, `stall`=0: if data is available, the oldest entry (or bypass) loads into `if_pc`/`if_insn` with `if_en`=1. Otherwise `if_en`=0 and `if_insn`=`ISA_NOP`; `if_pc` holds.
- Output, `stall`=1: `if_pc`/`if_insn`/`if_en` hold.
- Redirect (flush, or br_taken without stall):
  - `fetch_pc` <= target.
  - Buffer cleared; next-cycle output is a bubble (`if_en`=0, NOP).
  - If a request is outstanding and `imem_rdy`=0: enter `DISCARD`.
  - If `imem_rdy`=1 in the same cycle, the response is dropped and the FSM stays in `FETCH`.
- `DISCARD`: hold the old request until `imem_rdy`, drop that data, go to `FETCH`. The next request uses the new `fetch_pc`. A further redirect in `DISCARD` only updates `fetch_pc`.
- Reset values:
  - `if_pc`=`RESET_VECTOR`, `if_insn`=`ISA_NOP`, `if_en`=0.
  - `imem_req`=0, `busy`=0, `imem_addr`=`RESET_VECTOR`.
  - `fetch_pc`=`RESET_VECTOR`, buffer empty, FSM=`FETCH`.
- Reset mid-transaction: the outstanding request is abandoned. The memory side must tolerate `imem_req` dropping on reset.

## Timing
- `imem_req` first asserts the cycle after `reset` deasserts.
- Zero-wait memory (`imem_rdy` in the request cycle): response in cycle N gives `if_en`=1 in N+1. Sustained throughput is 1 instruction/cycle.
- Each wait cycle inserts one bubble.
- Redirect in cycle N: bubble in N+1. The first target instruction arrives at the earliest in N+2 (zero-wait, no discard).
- `busy` is combinational from `imem_req`/`imem_rdy`.

## Configuration
- `IF_PREFETCH_EN` defined: D=2. Requests continue during `stall` while buffer space remains, hiding one memory latency after a stall releases.
- `IF_PREFETCH_EN` undefined: D=1. No new request launches while `stall`=1 or the buffer is non-empty. A response arriving under stall is captured in the single entry. Cycle behaviour without stalls is identical to D=2.

## Structure
- Shared header/package:
  - `ISA_NOP` (32'h0), `WordAddrBus`/`WORD_ADDR_W`, `WordDataBus`.
  - FSM encodings `IF_ST_FETCH`/`IF_ST_DISCARD`.
  - `IF_BUF_DEPTH`, derived from `IF_PREFETCH_EN`.
- Sub-module `if_fetch_buf`: synchronous FIFO of {pc, insn}, depth `IF_BUF_DEPTH`, with push/pop/clear and count. Clear has priority over push.

## Test plan
- Reset release, zero-wait memory returning word = address: `imem_addr` 0,1,2…; `if_pc` 0,1,2 with `if_en`=1 from the second cycle after reset; `if_insn` equals `if_pc`.
- Memory with 2 wait cycles per fetch: `imem_addr` stable during waits, `busy`=1 for 2 cycles, output `if_en` pattern 0,0,1 repeating, no PC skipped.
- `br_taken`=1, `br_addr`=30'h100 while a fetch is pending with 3 waits: old response dropped, one request to 0x100 follows, next valid `if_pc`=0x100, no stale insn emitted.
- `stall` held 4 cycles mid-stream: output frozen. With `IF_PREFETCH_EN`, 2 extra fetches are issued and buffered, then drain back-to-back. Without it, at most 1 is captured, and all PCs are delivered in order.
- `flush` and `br_taken` in the same cycle, `new_pc`=0x40, `br_addr`=0x80, with `stall`=1: the next valid `if_pc`=0x40.
- `fetch_pc`=30'h3FFF_FFFF: the following fetch address is 0.
